log_error_pipe: RTL
===================

LOG_ERROR_PIPE -- requirements
Module: log_error_pipe

Interface
REQ-001 SHALL have parameters: WIDTH, default 16, sample/error width; QP, default 12, input fraction bits; FRAC_W, default 12, log mantissa bits; NCH, default 4, channel-tag count; MU_SHIFT_W, default 4, width of the mu_shift port.
REQ-002 SHALL derive, without override: POS_W = clog2(WIDTH); CH_W = max(1, clog2(NCH)); LOG_WIDTH = POS_W+1+FRAC_W (17 at defaults).
REQ-003 SHALL have ports (clock and reset first):
 clk  in  1  sole clock, rising edge
 rst_n  in  1  asynchronous active-low reset
 in_valid  in  1  input sample valid
 in_ready  out  1  block can accept input
 desired_in  in  WIDTH  signed desired sample, Q(WIDTH-QP).QP
 filter_out  in  WIDTH  signed filter output, same format
 ch_in  in  CH_W  channel tag
 mu_shift  in  MU_SHIFT_W  step-size shift, sampled on accept
 out_valid  out  1  result valid
 out_ready  in  1  downstream accepts result
 error  out  WIDTH  signed saturated desired_in-filter_out
 log_error  out  LOG_WIDTH  {pos-QP signed POS_W+1, fraction FRAC_W}
 log_error_sign  out  1  sign of shifted error
 log_error_valid  out  1  shifted error non-zero
 error_sat  out  1  subtraction saturated for this result
 ch_out  out  CH_W  tag carried with result
 sat_sticky  out  NCH  per-channel sticky saturation flags
 sat_clr  in  NCH  per-channel sticky clear

Function
REQ-004 SHALL be a 3-stage pipeline, latency 3 cycles from accept to out_valid, throughput 1 result/cycle.
REQ-005 SHALL accept on in_valid&&in_ready and deliver on out_valid&&out_ready; advance = !out_valid || out_ready; in_ready = advance.
REQ-006 SHALL stall all stages together when advance=0, holding every output stable; results are neither dropped nor reordered.
REQ-007 Stage 1 SHALL compute the difference in WIDTH+1 bits and saturate it to [-2^(WIDTH-1), 2^(WIDTH-1)-1], setting error_sat when clipped.
REQ-008 Stage 1 SHALL form es = (err + 2^(mu_shift-1)) >>> mu_shift in WIDTH+1 bits for mu_shift>0, and es = err for mu_shift=0.
REQ-009 Stage 2 SHALL register sign = es MSB and abs = |es| as exact unsigned WIDTH bits.
REQ-010 Stage 3 SHALL output pos = index of leading one of abs and fraction = bits below that one, left-aligned into FRAC_W bits (truncated or zero-padded); log_error = {pos-QP, fraction}.
REQ-011 When abs=0, SHALL output log_error_valid=0 and log_error=0, with log_error_sign passed through.
REQ-012 SHALL carry ch_in and error_sat with each sample to ch_out and error_sat.
REQ-013 SHALL set sat_sticky[ch] when a result with error_sat=1 is delivered on channel ch, and clear it when sat_clr[ch]=1; on the same cycle, set wins.
REQ-014 A ch_in value >= NCH SHALL pass through unchanged to ch_out and SHALL NOT affect sat_sticky.

Reset
REQ-015 rst_n low SHALL asynchronously clear all stage valids, out_valid, error, log_error, log_error_sign, log_error_valid, error_sat, ch_out and sat_sticky to 0.
REQ-016 Reset mid-operation SHALL discard all in-flight samples; in_ready=1 on the first clock after release.

Structure
REQ-017 The log-domain format constants (POS_W, LOG_WIDTH derivation, zero log code) SHALL live in shared package log_pkg.
REQ-018 The leading-one/Mitchell approximation SHALL be sub-module log1_n, parameterised by WIDTH and FRAC_W, outputting pos, fraction and valid.

Verification
REQ-019 SHALL cover, at defaults, these directed scenarios:
 desired=0x1000, filter=0, mu=7 -> error=0x1000, log_error=0x19000, sign=0, valid=1, 3 cycles after accept.
 desired=0, filter=0x0300, mu=7 -> error=0xFD00, log_error=0x16800, sign=1, valid=1.
 desired=filter=0x0010, mu=7 -> log_error_valid=0, log_error=0.
 desired=0x7FFF, filter=0x8000, mu=0, ch=2 -> error=0x7FFF, error_sat=1, log_error=0x02FFF, sat_sticky[2]=1; sat_clr[2] and a new saturation on the same cycle -> stays 1.
 Continuous in_valid with out_ready=0 for 6 cycles -> exactly 3 accepted, in_ready=0 after; release -> all results in order, none lost.
 rst_n low with 3 samples in flight -> out_valid=0 immediately; no stale result after release.

Source files
------------

// File: rtl/log_pkg.sv
// Log-domain format helpers shared by the error pipeline and its leading-one
// converter: field widths and the code emitted for a zero magnitude.
package log_pkg;

  // Bits needed to index any bit position of a WIDTH-bit magnitude.
  function automatic int pos_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  // log word = {signed exponent (pos_width+1), mantissa fraction}.
  function automatic int log_width(input int width, input int frac_w);
    return pos_width(width) + 1 + frac_w;
  endfunction

  localparam int LOG_ZERO = 0;

endpackage

// File: rtl/log1_n.sv
// Leading-one detector with Mitchell mantissa: pos is the index of the top set
// bit, fraction holds the bits beneath it, left-aligned into FRAC_W bits.
module log1_n
  import log_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int FRAC_W = 12,
  localparam int POS_W = pos_width(WIDTH)
) (
  input  logic [WIDTH-1:0]  abs_i,
  output logic [POS_W-1:0]  pos_o,
  output logic [FRAC_W-1:0] fraction_o,
  output logic              valid_o
);

  localparam int BW = WIDTH - 1;

  logic [BW-1:0] below;

  always_comb begin
    pos_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (abs_i[i]) pos_o = POS_W'(i);
    end
  end

  // Normalise so the leading one sits just above the kept bits, then drop it.
  assign below   = BW'(abs_i << (POS_W'(WIDTH - 1) - pos_o));
  assign valid_o = |abs_i;

  if (FRAC_W >= BW) begin : g_pad
    assign fraction_o = FRAC_W'(below) << (FRAC_W - BW);
  end else begin : g_trunc
    assign fraction_o = FRAC_W'(below >> (BW - FRAC_W));
  end

endmodule

// File: rtl/log_error_pipe.sv
// Three-stage error pipeline: saturated difference and rounded step-size
// shift, sign/magnitude split, then log2 conversion with per-channel stickies.
module log_error_pipe
  import log_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int QP         = 12,
  parameter int FRAC_W     = 12,
  parameter int NCH        = 4,
  parameter int MU_SHIFT_W = 4,
  localparam int POS_W     = pos_width(WIDTH),
  localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int LOG_WIDTH = log_width(WIDTH, FRAC_W)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      desired_in,
  input  logic [WIDTH-1:0]      filter_out,
  input  logic [CH_W-1:0]       ch_in,
  input  logic [MU_SHIFT_W-1:0] mu_shift,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      error,
  output logic [LOG_WIDTH-1:0]  log_error,
  output logic                  log_error_sign,
  output logic                  log_error_valid,
  output logic                  error_sat,
  output logic [CH_W-1:0]       ch_out,
  output logic [NCH-1:0]        sat_sticky,
  input  logic [NCH-1:0]        sat_clr
);

  // Handshake: a sample is taken on in_valid && in_ready, a result leaves on
  // out_valid && out_ready; every stage moves together only when advance=1.
  logic advance;
  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  logic signed [WIDTH:0] diff, err_x, es_d;
  logic [WIDTH-1:0]      err_d;
  logic                  clip_d;
  logic [WIDTH:0]        rnd;

  logic                 s1_valid_q, s2_valid_q;
  logic [WIDTH-1:0]     s1_err_q, s2_err_q, s2_abs_q, s2_abs_d;
  logic signed [WIDTH:0] s1_es_q;
  logic                 s1_sat_q, s2_sat_q, s2_sign_q;
  logic [CH_W-1:0]      s1_ch_q, s2_ch_q;

  logic                 out_valid_q, sign_q, lvalid_q, sat_q;
  logic [WIDTH-1:0]     error_q;
  logic [LOG_WIDTH-1:0] log_q, log_d;
  logic [CH_W-1:0]      ch_q;
  logic [NCH-1:0]       sticky_q, sticky_d, sticky_set;

  logic [POS_W-1:0]  l_pos;
  logic [FRAC_W-1:0] l_frac;
  logic              l_valid;
  logic [POS_W:0]    pos_rel;

  always_comb begin
    diff   = $signed({desired_in[WIDTH-1], desired_in}) - $signed({filter_out[WIDTH-1], filter_out});
    clip_d = diff[WIDTH] ^ diff[WIDTH-1];
    if (!clip_d)          err_d = diff[WIDTH-1:0];
    else if (diff[WIDTH]) err_d = {1'b1, {(WIDTH-1){1'b0}}};
    else                  err_d = {1'b0, {(WIDTH-1){1'b1}}};
    err_x = $signed({err_d[WIDTH-1], err_d});
    rnd   = (WIDTH + 1)'(1) << (mu_shift - 1'b1);
    if (mu_shift == '0) es_d = err_x;
    else                es_d = (err_x + $signed(rnd)) >>> mu_shift;
  end

  // |es| always fits WIDTH unsigned bits: the most negative es is -2^(WIDTH-1).
  assign s2_abs_d = s1_es_q[WIDTH] ? WIDTH'(-s1_es_q) : s1_es_q[WIDTH-1:0];

  log1_n #(.WIDTH(WIDTH), .FRAC_W(FRAC_W)) u_log1 (
    .abs_i      (s2_abs_q),
    .pos_o      (l_pos),
    .fraction_o (l_frac),
    .valid_o    (l_valid)
  );

  assign pos_rel = {1'b0, l_pos} - (POS_W + 1)'(QP);
  assign log_d   = l_valid ? {pos_rel, l_frac} : LOG_WIDTH'(LOG_ZERO);

  // Tags at or above NCH match no loop index, so they never touch the flags.
  always_comb begin
    sticky_set = '0;
    for (int c = 0; c < NCH; c++) begin
      if (out_valid_q && out_ready && sat_q && ch_q == CH_W'(c)) sticky_set[c] = 1'b1;
    end
    sticky_d = (sticky_q & ~sat_clr) | sticky_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_err_q    <= '0;
      s1_es_q     <= '0;
      s1_sat_q    <= 1'b0;
      s1_ch_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_err_q    <= '0;
      s2_abs_q    <= '0;
      s2_sign_q   <= 1'b0;
      s2_sat_q    <= 1'b0;
      s2_ch_q     <= '0;
      out_valid_q <= 1'b0;
      error_q     <= '0;
      log_q       <= '0;
      sign_q      <= 1'b0;
      lvalid_q    <= 1'b0;
      sat_q       <= 1'b0;
      ch_q        <= '0;
      sticky_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      if (advance) begin
        s1_valid_q  <= in_valid;
        s1_err_q    <= err_d;
        s1_es_q     <= es_d;
        s1_sat_q    <= clip_d;
        s1_ch_q     <= ch_in;
        s2_valid_q  <= s1_valid_q;
        s2_err_q    <= s1_err_q;
        s2_abs_q    <= s2_abs_d;
        s2_sign_q   <= s1_es_q[WIDTH];
        s2_sat_q    <= s1_sat_q;
        s2_ch_q     <= s1_ch_q;
        out_valid_q <= s2_valid_q;
        error_q     <= s2_err_q;
        log_q       <= log_d;
        sign_q      <= s2_sign_q;
        lvalid_q    <= l_valid;
        sat_q       <= s2_sat_q;
        ch_q        <= s2_ch_q;
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign error           = error_q;
  assign log_error       = log_q;
  assign log_error_sign  = sign_q;
  assign log_error_valid = lvalid_q;
  assign error_sat       = sat_q;
  assign ch_out          = ch_q;
  assign sat_sticky      = sticky_q;

endmodule
